// File: rtl/coll_pkg.sv
// -----------------------------------------------------------------------------
// coll_pkg
// Shared definitions for the collection-run controller and the APB register
// block that drives it.
//   - coll_state_e   : encoded controller state (also read back as status)
//   - LENGTH_ADD_DEF : default bin address width
//   - WIN_W_DEF      : default window/sample counter width
//   - REG_*          : register offsets used by the register block
// The optional continuous mode of coll_ctrl is selected with the macro
// COLL_CTRL_CONT_EN; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package coll_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COLLECT = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } coll_state_e;

    localparam int LENGTH_ADD_DEF = 5;
    localparam int WIN_W_DEF      = 16;

    localparam logic [7:0] REG_CTRL    = 8'h00; // StartColl bit
    localparam logic [7:0] REG_WIN_LEN = 8'h10; // window length
    localparam logic [7:0] REG_STATUS  = 8'h14; // state / done / sample count

endpackage

// File: rtl/coll_edge_det.sv
// -----------------------------------------------------------------------------
// coll_edge_det
// Registered edge detector for the StartColl level.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   din       : level input (start_coll)
//   rise      : din high this cycle, low last cycle
//   fall      : din low this cycle, high last cycle
// -----------------------------------------------------------------------------
module coll_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) din_d <= 1'b0;
        else       din_d <= din;
    end

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/coll_ctrl.sv
// -----------------------------------------------------------------------------
// coll_ctrl
// Sequences one histogram/max-count collection run for the three collector
// channels: clear all bins, open a sample window of win_len samples, drain
// the collector pipeline, then report completion.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   start_coll  : StartColl level; rising edge starts, falling edge aborts/ends
//   win_len     : samples per window, latched at start
//   sample_vld  : collector sample strobe (one sample per high cycle; there is
//                 no back-pressure, samples outside COLLECT are ignored)
//   clr_en      : bin-clear write enable, clr_addr : bin being cleared
//   coll_en     : collectors accept samples while high
//   busy, done  : run in progress / run complete
//   state_o     : encoded state for the status register
//   smp_cnt     : samples counted in the current window
// Optional (macro COLL_CTRL_CONT_EN):
//   cont_mode   : restart automatically from DONE while start_coll is high
//   run_cnt     : number of DONE entries since reset (wraps)
// -----------------------------------------------------------------------------
module coll_ctrl
    import coll_pkg::*;
#(
    parameter int LENGTH_ADD = LENGTH_ADD_DEF,
    parameter int WIN_W      = WIN_W_DEF,
    parameter int DRAIN_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_coll,
    input  logic [WIN_W-1:0]      win_len,
    input  logic                  sample_vld,
`ifdef COLL_CTRL_CONT_EN
    input  logic                  cont_mode,
    output logic [15:0]           run_cnt,
`endif
    output logic                  clr_en,
    output logic [LENGTH_ADD-1:0] clr_addr,
    output logic                  coll_en,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_o,
    output logic [WIN_W-1:0]      smp_cnt
);

    // DRAIN_CYC of 0 or 1 both give a single DRAIN cycle.
    localparam int DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int DRAIN_LAST = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

    localparam logic [LENGTH_ADD-1:0] ADDR_LAST = {LENGTH_ADD{1'b1}};

    coll_state_e      state;
    logic [WIN_W-1:0] win_len_q;
    logic [DW-1:0]    drain_cnt;
    logic             rise;
    logic             fall;

    coll_edge_det u_edge (
        .clk  (clk),
        .rstn (rstn),
        .din  (start_coll),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            win_len_q <= '0;
            clr_addr  <= '0;
            smp_cnt   <= '0;
            drain_cnt <= '0;
`ifdef COLL_CTRL_CONT_EN
            run_cnt   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        win_len_q <= win_len;
                        clr_addr  <= '0;
                        smp_cnt   <= '0;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (fall) begin
                        state <= S_IDLE;
                    end else begin
                        clr_addr <= clr_addr + LENGTH_ADD'(1);
                        if (clr_addr == ADDR_LAST) begin
                            drain_cnt <= '0;
                            state     <= (win_len_q == '0) ? S_DRAIN : S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    // Abort has priority over the sample that would close the window.
                    if (fall) begin
                        state <= S_IDLE;
                    end else if (sample_vld && (smp_cnt < win_len_q)) begin
                        smp_cnt <= smp_cnt + WIN_W'(1);
                        if (smp_cnt == win_len_q - WIN_W'(1)) begin
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fall) begin
                        state <= S_IDLE;
                    end else if (drain_cnt == DW'(DRAIN_LAST)) begin
                        state <= S_DONE;
`ifdef COLL_CTRL_CONT_EN
                        run_cnt <= run_cnt + 16'd1;
`endif
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                S_DONE: begin
                    if (fall) begin
                        state <= S_IDLE;
`ifdef COLL_CTRL_CONT_EN
                    end else if (cont_mode && start_coll) begin
                        // Back-to-back window: DONE lasts exactly one cycle.
                        win_len_q <= win_len;
                        clr_addr  <= '0;
                        smp_cnt   <= '0;
                        state     <= S_CLEAR;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign clr_en  = (state == S_CLEAR);
    assign coll_en = (state == S_COLLECT);
    assign busy    = (state == S_CLEAR) || (state == S_COLLECT) || (state == S_DRAIN);
    assign done    = (state == S_DONE);
    assign state_o = state;

endmodule

// File: tb/tb_coll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coll_ctrl
// Directed self-checking bench for coll_ctrl with default parameters
// (32 bins, 16-bit window, 2 drain cycles). Continuous-mode checks are
// compiled in when COLL_CTRL_CONT_EN is defined.
// -----------------------------------------------------------------------------
module tb_coll_ctrl;

    localparam int LENGTH_ADD = 5;
    localparam int WIN_W      = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic                  start_coll;
    logic [WIN_W-1:0]      win_len;
    logic                  sample_vld;
    logic                  clr_en;
    logic [LENGTH_ADD-1:0] clr_addr;
    logic                  coll_en;
    logic                  busy;
    logic                  done;
    logic [2:0]            state_o;
    logic [WIN_W-1:0]      smp_cnt;
`ifdef COLL_CTRL_CONT_EN
    logic                  cont_mode;
    logic [15:0]           run_cnt;
`endif

    coll_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_coll (start_coll),
        .win_len    (win_len),
        .sample_vld (sample_vld),
`ifdef COLL_CTRL_CONT_EN
        .cont_mode  (cont_mode),
        .run_cnt    (run_cnt),
`endif
        .clr_en     (clr_en),
        .clr_addr   (clr_addr),
        .coll_en    (coll_en),
        .busy       (busy),
        .done       (done),
        .state_o    (state_o),
        .smp_cnt    (smp_cnt)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clr_en"},   32'(clr_en),   0);
        check({tag, "_clr_addr"}, 32'(clr_addr), 0);
        check({tag, "_coll_en"},  32'(coll_en),  0);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_done"},     32'(done),     0);
        check({tag, "_state"},    32'(state_o),  0);
        check({tag, "_smp_cnt"},  32'(smp_cnt),  0);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge right after start_coll has been raised. Observes
    // each cycle at negedge until done (bounded) and drives sample_vld:
    // mode 0 none, 1 every other COLLECT cycle, 2 every COLLECT cycle.
    task automatic run_measure(input int mode, input bit chg,
                               output int n_clr, output int n_coll, output int n_drain,
                               output int addr_err, output bit got_done);
        int ph = 0;
        n_clr = 0; n_coll = 0; n_drain = 0; addr_err = 0; got_done = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (clr_en) begin
                    if (int'(clr_addr) != n_clr) addr_err++;
                    n_clr++;
                end
                if (coll_en) begin
                    n_coll++;
                    if (chg) win_len = 16'd3;
                end
                if (busy && !clr_en && !coll_en) n_drain++;
            end
            if (coll_en) begin
                sample_vld = (mode == 2) || (mode == 1 && (ph % 2) == 0);
                ph++;
            end else begin
                sample_vld = 1'b0;
            end
        end
    endtask

    task automatic end_run(input string tag, input int exp_smp);
        start_coll = 1'b0;
        @(negedge clk);
        check({tag, "_end_state"}, 32'(state_o), 0);
        check({tag, "_end_done"},  32'(done),    0);
        check({tag, "_end_smp"},   32'(smp_cnt), exp_smp);
        @(negedge clk);
    endtask

    // Starts a run, turns on continuous samples in COLLECT and drops start_coll
    // (with sample_vld still high) once smp_cnt reaches at_cnt.
    task automatic abort_at(input string tag, input int at_cnt);
        bit hit = 1'b0;
        win_len    = 16'd10;
        start_coll = 1'b1;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            sample_vld = coll_en;
            if (coll_en && int'(smp_cnt) == at_cnt) hit = 1'b1;
        end
        check({tag, "_reached"}, 32'(hit), 1);
        start_coll = 1'b0;
        @(negedge clk);
        sample_vld = 1'b0;
        check({tag, "_state"},   32'(state_o), 0);
        check({tag, "_done"},    32'(done),    0);
        check({tag, "_coll_en"}, 32'(coll_en), 0);
        check({tag, "_smp"},     32'(smp_cnt), at_cnt);
        @(negedge clk);
        check({tag, "_smp_hold"}, 32'(smp_cnt), at_cnt);
    endtask

    // ---------------- stimulus ----------------
    int n_clr, n_coll, n_drain, addr_err;
    bit got_done;

    initial begin
        rstn       = 1'b0;
        start_coll = 1'b0;
        win_len    = '0;
        sample_vld = 1'b0;
`ifdef COLL_CTRL_CONT_EN
        cont_mode  = 1'b0;
`endif
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Test 1: win_len=10, samples every other cycle.
        win_len    = 16'd10;
        start_coll = 1'b1;
        run_measure(1, 1'b0, n_clr, n_coll, n_drain, addr_err, got_done);
        check("t1_done",     32'(got_done), 1);
        check("t1_n_clr",    32'(n_clr),    32);
        check("t1_addr_seq", 32'(addr_err), 0);
        check("t1_n_coll",   32'(n_coll),   19);
        check("t1_n_drain",  32'(n_drain),  2);
        check("t1_smp",      32'(smp_cnt),  10);
        check("t1_state",    32'(state_o),  4);
        check("t1_busy",     32'(busy),     0);
        repeat (3) @(negedge clk);
        check("t1_done_hold", 32'(done), 1);
        end_run("t1", 10);

        // Test 2: win_len=0 skips COLLECT.
        win_len    = 16'd0;
        start_coll = 1'b1;
        run_measure(1, 1'b0, n_clr, n_coll, n_drain, addr_err, got_done);
        check("t2_done",    32'(got_done), 1);
        check("t2_n_clr",   32'(n_clr),    32);
        check("t2_n_coll",  32'(n_coll),   0);
        check("t2_n_drain", 32'(n_drain),  2);
        check("t2_smp",     32'(smp_cnt),  0);
        end_run("t2", 0);

        // Test 3: abort in COLLECT at smp_cnt=4; last sample vs abort at 9.
        abort_at("t3a", 4);
        abort_at("t3b", 9);

        // Test 4: asynchronous reset mid-CLEAR at clr_addr=17.
        win_len    = 16'd10;
        start_coll = 1'b1;
        got_done   = 1'b0;
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(negedge clk);
            if (clr_en && clr_addr == 5'd17) got_done = 1'b1;
        end
        check("t4_reached", 32'(got_done), 1);
        rstn       = 1'b0;
        start_coll = 1'b0;
        #1;
        check_all_zero("t4_rst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start_coll = 1'b1;
        run_measure(1, 1'b0, n_clr, n_coll, n_drain, addr_err, got_done);
        check("t4_done",     32'(got_done), 1);
        check("t4_n_clr",    32'(n_clr),    32);
        check("t4_addr_seq", 32'(addr_err), 0);
        check("t4_smp",      32'(smp_cnt),  10);
        end_run("t4", 10);

        // Test 5: win_len changed to 3 during COLLECT is ignored.
        win_len    = 16'd10;
        start_coll = 1'b1;
        run_measure(1, 1'b1, n_clr, n_coll, n_drain, addr_err, got_done);
        check("t5_done",   32'(got_done), 1);
        check("t5_n_coll", 32'(n_coll),   19);
        check("t5_smp",    32'(smp_cnt),  10);
        end_run("t5", 10);

`ifdef COLL_CTRL_CONT_EN
        // Test 6: continuous mode, three back-to-back runs of 5 samples.
        begin
            int  pulses = 0;
            int  wide   = 0;
            bit  prev   = 1'b0;
            bit  fin    = 1'b0;
            rstn = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            check("t6_run_cnt_rst", 32'(run_cnt), 0);
            @(negedge clk);
            cont_mode  = 1'b1;
            win_len    = 16'd5;
            sample_vld = 1'b1;
            start_coll = 1'b1;
            for (int c = 0; c < 400 && !fin; c++) begin
                @(negedge clk);
                if (done) begin
                    if (prev) wide++;
                    else      pulses++;
                    if (pulses == 3) begin
                        check("t6_run_cnt", 32'(run_cnt), 3);
                        check("t6_smp",     32'(smp_cnt), 5);
                        start_coll = 1'b0;
                        fin = 1'b1;
                    end
                end
                prev = done;
            end
            check("t6_pulses", 32'(pulses), 3);
            check("t6_wide",   32'(wide),   0);
            @(negedge clk);
            sample_vld = 1'b0;
            check("t6_end_state",   32'(state_o), 0);
            check("t6_end_done",    32'(done),    0);
            check("t6_end_run_cnt", 32'(run_cnt), 3);
        end
`endif

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/coll_ctrl.md
Name: coll_ctrl

Overview:
Sequences one histogram/max-count collection run for the three collector channels.
- Triggered by the StartColl register bit.
- Clears the collector bins, opens a sample window of programmable length, drains the collector pipeline, then signals completion.
- Sits between the APB register block (start bit, window length, status/done) and the three collectors (clear, enable).

Parameters:
- LENGTH_ADD, 5: bin address width; the clear phase sweeps 2**LENGTH_ADD bins.
- WIN_W, 16: width of the window-length and sample counters.
- DRAIN_CYC, 2: collector pipeline depth; cycles of idle drain after the window closes.

Ports:
- clk, input, 1: clock clk.
- rstn, input, 1: reset, asynchronous, active-low.
- start_coll, input, 1: level from the register block; rising edge starts a run, falling edge aborts it.
- win_len, input, WIN_W: number of valid samples per window; sampled at start.
- sample_vld, input, 1: collector input sample strobe.
- clr_en, output, 1: collector bin-clear write enable.
- clr_addr, output, LENGTH_ADD: bin address being cleared.
- coll_en, output, 1: collectors accept samples while high.
- busy, output, 1: run in progress (CLEAR, COLLECT or DRAIN).
- done, output, 1: run completed; results valid for register readback.
- state_o, output, 3: encoded state, for the status register.
- smp_cnt, output, WIN_W: samples counted in the current window.

Behaviour:
- States: IDLE=0, CLEAR=1, COLLECT=2, DRAIN=3, DONE=4. Moore outputs decoded from the state register; all counters registered.
- Reset values: state IDLE; clr_en 0; clr_addr 0; coll_en 0; busy 0; done 0; smp_cnt 0; start_d 0; win_len_q 0.
- start_d is start_coll registered. rise = start_coll & ~start_d; fall = ~start_coll & start_d.
- IDLE:
  - On rise, latch win_len into win_len_q, zero clr_addr and smp_cnt, go to CLEAR.
  - The first CLEAR cycle is the cycle after the rise is sampled.
- CLEAR:
  - clr_en=1 and clr_addr increments every cycle.
  - When clr_addr == 2**LENGTH_ADD-1: go to COLLECT next cycle, or straight to DRAIN if win_len_q == 0.
  - Duration is exactly 2**LENGTH_ADD cycles.
- COLLECT:
  - coll_en=1.
  - Each cycle with sample_vld: smp_cnt += 1.
  - When sample_vld && smp_cnt == win_len_q-1, the increment completes the window: go to DRAIN.
  - smp_cnt saturates at win_len_q and never wraps.
- DRAIN:
  - coll_en=0; a drain counter runs DRAIN_CYC cycles, then go to DONE.
  - DRAIN_CYC=0 means a single-cycle DRAIN.
- DONE:
  - done=1 and busy=0; held while start_coll stays high.
  - On fall, go to IDLE and clear done.
  - smp_cnt is held for readback until the next start.
- Abort: fall in CLEAR, COLLECT or DRAIN → IDLE next cycle.
  - done is not set; clr_en and coll_en drop immediately with the state.
  - smp_cnt is held.
- Simultaneous events:
  - A rise while busy is impossible (start_coll is already high).
  - The last sample and fall in the same cycle: abort wins.
- Asynchronous reset mid-run: all outputs return to reset values immediately; no partial clear is resumed.
- win_len changes during a run are ignored, because the value is latched.

Optional Feature:
- Macro: COLL_CTRL_CONT_EN.
- Defined:
  - Adds input cont_mode (1 bit).
  - In DONE with cont_mode=1 and start_coll high, done pulses for exactly one cycle, then the FSM re-enters CLEAR with win_len re-latched. This gives back-to-back windows.
  - Adds output run_cnt [15:0], which increments on each DONE entry, wraps at 16'hFFFF→0, and resets to 0.
- Undefined: single-shot behaviour as above; neither port exists.

Decomposition:
- Shared package coll_pkg:
  - State encoding constants.
  - Default LENGTH_ADD and WIN_W.
  - Register-offset constants (0x00 control, 0x10 window length, 0x14 status/sample count) used with the register block.
- One natural sub-module, coll_edge_det: registered rise/fall detector for start_coll. Everything else stays in coll_ctrl.

Test Plan:
- Defaults, win_len=10, start rise at cycle 0, sample_vld every other cycle:
  - clr_en high for 32 cycles with clr_addr 0..31.
  - coll_en high for 19 cycles.
  - DRAIN 2 cycles, then done=1 and smp_cnt=10.
- win_len=0: CLEAR 32 cycles → DRAIN → done=1; coll_en never asserts; smp_cnt=0.
- start_coll dropped at COLLECT with smp_cnt=4: IDLE next cycle, done=0, smp_cnt stays 4, coll_en=0.
- rstn asserted mid-CLEAR at clr_addr=17: all outputs 0 asynchronously. After release plus a new rise, the clear restarts at addr 0.
- win_len changed from 10 to 3 during COLLECT: window still closes at 10 samples.
- COLL_CTRL_CONT_EN with cont_mode=1 and win_len=5, continuous samples:
  - Three consecutive runs, each with a one-cycle done pulse.
  - run_cnt reads 3.
  - Dropping start_coll ends the sequence in IDLE.
